// File: rtl/data_sram_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : data_sram_req_ctrl
// Description : Drives EX-stage load/store requests onto an SRAM-like data
//               bus (req/addr_ok/data_ok), tracks outstanding transactions,
//               and buffers returned data in a FIFO so MEM may stall.
//               Responses belonging to flushed instructions are discarded.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, resetn            : clock / asynchronous active-low reset
//   ex_req_*               : request from EX (valid/ready handshake)
//   flush                  : cancel every request not yet returned to MEM
//   mem_resp_*             : FIFO head towards MEM (valid/ready handshake)
//   data_sram_*            : SRAM-like bus master side
//   busy                   : request pending, in flight, or being discarded
// ============================================================================
module data_sram_req_ctrl #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ex_req_valid,
    input  logic        ex_req_wr,
    input  logic [1:0]  ex_req_size,
    input  logic [3:0]  ex_req_wstrb,
    input  logic [31:0] ex_req_addr,
    input  logic [31:0] ex_req_wdata,
    output logic        ex_req_ready,
    input  logic        flush,
    output logic        mem_resp_valid,
    output logic        mem_resp_wr,
    output logic [31:0] mem_resp_rdata,
    input  logic        mem_resp_ready,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    output logic        busy
);

    localparam int               AW       = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    // Discarded transactions can pile up across back-to-back flushes, so this
    // counter is given headroom beyond the admission bound.
    localparam int               DW       = CNT_W + 2;
    localparam logic [CNT_W:0]   MAX_C    = (CNT_W + 1)'(MAX_OUTSTANDING);
    localparam logic [AW-1:0]    LAST_PTR = AW'(MAX_OUTSTANDING - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    state_e              state_q, state_d;

    logic                req_wr_q;
    logic [1:0]          req_size_q;
    logic [3:0]          req_wstrb_q;
    logic [31:0]         req_addr_q;
    logic [31:0]         req_wdata_q;
    logic                req_disc_q, req_disc_d;

    logic [CNT_W-1:0]    inflight_q, inflight_d;
    logic [CNT_W-1:0]    fifo_cnt_q, fifo_cnt_d;
    logic [DW-1:0]       discard_q,  discard_d;

    // Per-transaction wr tags for live in-flight requests, oldest at tag_rp_q
    logic [MAX_OUTSTANDING-1:0] tag_q;
    logic [AW-1:0]              tag_wp_q, tag_rp_q;

    // Response FIFO
    logic [31:0]                fifo_data_q [MAX_OUTSTANDING];
    logic [MAX_OUTSTANDING-1:0] fifo_wr_q;
    logic [AW-1:0]              fifo_wp_q, fifo_rp_q;

    logic w_accept, w_addr_hs, w_hs_keep, w_hs_disc;
    logic w_drop_disc, w_resp, w_keep, w_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign ex_req_ready = (state_q == ST_IDLE) & ~flush &
                          (({1'b0, inflight_q} + {1'b0, fifo_cnt_q}) < MAX_C);

    assign w_accept    = ex_req_valid & ex_req_ready;
    assign w_addr_hs   = (state_q == ST_REQ) & data_sram_addr_ok;
    // A request already on the bus cannot be retracted; if it was flushed it
    // still completes on the bus but its data is scheduled for discard.
    assign w_hs_disc   = w_addr_hs & (req_disc_q | flush);
    assign w_hs_keep   = w_addr_hs & ~req_disc_q & ~flush;
    // Data returns in order, so discarded transactions are always the oldest.
    assign w_drop_disc = data_sram_data_ok & (discard_q != '0);
    assign w_resp      = data_sram_data_ok & (discard_q == '0) & (inflight_q != '0);
    assign w_keep      = w_resp & ~flush;
    assign w_pop       = mem_resp_valid & mem_resp_ready;

    assign data_sram_req   = (state_q == ST_REQ);
    assign data_sram_wr    = req_wr_q;
    assign data_sram_size  = req_size_q;
    assign data_sram_wstrb = req_wstrb_q;
    assign data_sram_addr  = req_addr_q;
    assign data_sram_wdata = req_wdata_q;

    assign mem_resp_valid = (fifo_cnt_q != '0);
    assign mem_resp_wr    = fifo_wr_q[fifo_rp_q];
    assign mem_resp_rdata = fifo_data_q[fifo_rp_q];

    assign busy = (state_q == ST_REQ) | (inflight_q != '0) | (discard_q != '0);

    always_comb begin
        state_d    = state_q;
        req_disc_d = req_disc_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    state_d    = ST_REQ;
                    req_disc_d = 1'b0;
                end
            end
            ST_REQ: begin
                if (w_addr_hs) begin
                    state_d    = ST_IDLE;
                    req_disc_d = 1'b0;
                end else if (flush) begin
                    req_disc_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        inflight_d = flush ? '0 : (inflight_q + CNT_W'(w_hs_keep) - CNT_W'(w_keep));
        fifo_cnt_d = flush ? '0 : (fifo_cnt_q + CNT_W'(w_keep) - CNT_W'(w_pop));
        // A live response returning in the flush cycle is dropped here and
        // so must not also be counted into the discard backlog.
        discard_d  = discard_q - DW'(w_drop_disc) + DW'(w_hs_disc) +
                     (flush ? (DW'(inflight_q) - DW'(w_resp)) : '0);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            req_wr_q    <= 1'b0;
            req_size_q  <= '0;
            req_wstrb_q <= '0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_disc_q  <= 1'b0;
            inflight_q  <= '0;
            fifo_cnt_q  <= '0;
            discard_q   <= '0;
            tag_q       <= '0;
            tag_wp_q    <= '0;
            tag_rp_q    <= '0;
            fifo_wr_q   <= '0;
            fifo_wp_q   <= '0;
            fifo_rp_q   <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_data_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            req_disc_q <= req_disc_d;
            inflight_q <= inflight_d;
            fifo_cnt_q <= fifo_cnt_d;
            discard_q  <= discard_d;

            if (w_accept) begin
                req_wr_q    <= ex_req_wr;
                req_size_q  <= ex_req_size;
                req_wstrb_q <= ex_req_wstrb;
                req_addr_q  <= ex_req_addr;
                req_wdata_q <= ex_req_wdata;
            end

            if (flush) begin
                tag_wp_q  <= '0;
                tag_rp_q  <= '0;
                fifo_wp_q <= '0;
                fifo_rp_q <= '0;
            end else begin
                if (w_hs_keep) begin
                    tag_q[tag_wp_q] <= req_wr_q;
                    tag_wp_q        <= ptr_inc(tag_wp_q);
                end
                if (w_keep) begin
                    tag_rp_q               <= ptr_inc(tag_rp_q);
                    fifo_data_q[fifo_wp_q] <= data_sram_rdata;
                    fifo_wr_q[fifo_wp_q]   <= tag_q[tag_rp_q];
                    fifo_wp_q              <= ptr_inc(fifo_wp_q);
                end
                if (w_pop) begin
                    fifo_rp_q <= ptr_inc(fifo_rp_q);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_sram_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_sram_req_ctrl
// Description : Self-checking bench for data_sram_req_ctrl. A transaction-level
//               model tracks the pending request, bus transactions (live or
//               cancelled) and the responses MEM should see.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_sram_req_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ex_req_valid, ex_req_wr, ex_req_ready, flush;
    logic [1:0]  ex_req_size;
    logic [3:0]  ex_req_wstrb;
    logic [31:0] ex_req_addr, ex_req_wdata;
    logic        mem_resp_valid, mem_resp_wr, mem_resp_ready;
    logic [31:0] mem_resp_rdata;
    logic        data_sram_req, data_sram_wr, data_sram_addr_ok, data_sram_data_ok;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
    logic        busy;

    always #5 clk = ~clk;

    data_sram_req_ctrl #(.MAX_OUTSTANDING(2), .CNT_W(2)) dut (
        .clk(clk), .resetn(resetn),
        .ex_req_valid(ex_req_valid), .ex_req_wr(ex_req_wr), .ex_req_size(ex_req_size),
        .ex_req_wstrb(ex_req_wstrb), .ex_req_addr(ex_req_addr), .ex_req_wdata(ex_req_wdata),
        .ex_req_ready(ex_req_ready), .flush(flush),
        .mem_resp_valid(mem_resp_valid), .mem_resp_wr(mem_resp_wr),
        .mem_resp_rdata(mem_resp_rdata), .mem_resp_ready(mem_resp_ready),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata), .busy(busy)
    );

    typedef struct {logic wr; logic live;} bus_t;
    typedef struct {logic wr; logic [31:0] data;} resp_t;

    // Reference model state
    logic        pend_valid, pend_wr, pend_live;
    logic [1:0]  pend_size;
    logic [3:0]  pend_wstrb;
    logic [31:0] pend_addr, pend_wdata;
    bus_t        bus_q[$];
    resp_t       exp_q[$];
    logic        exp_ready;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic int live_cnt();
        int n = 0;
        foreach (bus_q[i]) if (bus_q[i].live) n++;
        return n;
    endfunction

    task automatic model_reset();
        pend_valid = 0; pend_wr = 0; pend_live = 0;
        pend_size = 0; pend_wstrb = 0; pend_addr = 0; pend_wdata = 0;
        bus_q.delete();
        exp_q.delete();
    endtask

    task automatic check_outputs();
        exp_ready = !pend_valid && !flush && ((live_cnt() + exp_q.size()) < 2);
        chk("ex_req_ready", 32'(ex_req_ready), 32'(exp_ready));
        chk("data_sram_req", 32'(data_sram_req), 32'(pend_valid));
        if (pend_valid) begin
            chk("bus_wr", 32'(data_sram_wr), 32'(pend_wr));
            chk("bus_size", 32'(data_sram_size), 32'(pend_size));
            chk("bus_wstrb", 32'(data_sram_wstrb), 32'(pend_wstrb));
            chk("bus_addr", data_sram_addr, pend_addr);
            chk("bus_wdata", data_sram_wdata, pend_wdata);
        end
        chk("resp_valid", 32'(mem_resp_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("resp_wr", 32'(mem_resp_wr), 32'(exp_q[0].wr));
            chk("resp_rdata", mem_resp_rdata, exp_q[0].data);
        end
        chk("busy", 32'(busy), 32'(pend_valid || bus_q.size() != 0));
    endtask

    // One clock: drive at negedge, check, then advance the model at posedge.
    task automatic cycle(input logic v, input logic wr, input logic [1:0] sz,
                         input logic [3:0] st, input logic [31:0] a, input logic [31:0] wd,
                         input logic fl, input logic mr, input logic aok,
                         input logic dok, input logic [31:0] rd);
        bus_t  b;
        resp_t r;
        logic  acc;
        @(negedge clk);
        ex_req_valid = v; ex_req_wr = wr; ex_req_size = sz; ex_req_wstrb = st;
        ex_req_addr = a; ex_req_wdata = wd; flush = fl; mem_resp_ready = mr;
        data_sram_addr_ok = aok & pend_valid;
        data_sram_data_ok = dok & (bus_q.size() != 0);
        data_sram_rdata = rd;
        #1;
        check_outputs();
        acc = v && exp_ready;
        @(posedge clk);
        if (mr && exp_q.size() != 0) void'(exp_q.pop_front());
        if (data_sram_data_ok) begin
            b = bus_q.pop_front();
            if (b.live && !fl) begin
                r.wr = b.wr; r.data = rd;
                exp_q.push_back(r);
            end
        end
        if (data_sram_addr_ok) begin
            b.wr = pend_wr; b.live = pend_live && !fl;
            bus_q.push_back(b);
            pend_valid = 0;
        end
        if (fl) begin
            foreach (bus_q[i]) bus_q[i].live = 1'b0;
            exp_q.delete();
            pend_live = 1'b0;
        end
        if (acc) begin
            pend_valid = 1; pend_live = 1; pend_wr = wr; pend_size = sz;
            pend_wstrb = st; pend_addr = a; pend_wdata = wd;
        end
    endtask

    task automatic rand_cycle(input int fl_mod, input int mr_mod);
        cycle($urandom % 2, $urandom % 2, 2'($urandom % 3), 4'($urandom), $urandom, $urandom,
              ($urandom % fl_mod) == 0, ($urandom % mr_mod) == 0,
              $urandom % 2, $urandom % 2, $urandom);
    endtask

    initial begin
        resetn = 0; ex_req_valid = 0; ex_req_wr = 0; ex_req_size = 0; ex_req_wstrb = 0;
        ex_req_addr = 0; ex_req_wdata = 0; flush = 0; mem_resp_ready = 0;
        data_sram_addr_ok = 0; data_sram_data_ok = 0; data_sram_rdata = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(data_sram_req), 0);
        chk("rst_resp_valid", 32'(mem_resp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_addr", data_sram_addr, 0);
        chk("rst_rdata", mem_resp_rdata, 0);
        @(negedge clk);
        resetn = 1;

        // Directed load: addr_ok two cycles after req, data_ok next cycle
        cycle(1, 0, 2, 4'hF, 32'h1000, 0, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("load_rdata", mem_resp_rdata, 32'hDEADBEEF);
        chk("load_wr", 32'(mem_resp_wr), 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

        // Directed store
        cycle(1, 1, 1, 4'b1100, 32'h2002, 32'h12340000, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h5);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

        // Flush while REQ waits with one live transaction in flight
        cycle(1, 0, 2, 4'hF, 32'h30, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        cycle(1, 0, 2, 4'hF, 32'h34, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hAA);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hBB);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

        // Randomized traffic: general, MEM stalling, flush-heavy
        for (int i = 0; i < 1500; i++) rand_cycle(24, 2);
        for (int i = 0; i < 800;  i++) rand_cycle(40, 8);
        for (int i = 0; i < 800;  i++) rand_cycle(5, 2);

        // Reset mid-traffic once responses are buffered
        for (int i = 0; i < 200 && exp_q.size() == 0; i++) rand_cycle(1000, 1000);
        @(negedge clk);
        resetn = 0;
        #1;
        chk("mid_rst_req", 32'(data_sram_req), 0);
        chk("mid_rst_resp_valid", 32'(mem_resp_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_rdata", mem_resp_rdata, 0);
        model_reset();
        ex_req_valid = 0; flush = 0; data_sram_addr_ok = 0; data_sram_data_ok = 0;
        @(negedge clk);
        resetn = 1;
        cycle(1, 0, 2, 4'hF, 32'h4000, 0, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 500; i++) rand_cycle(16, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
